// File: rtl/key_pkg.sv
// Shared definitions for the push-button path: FSM states, pin polarity and
// the default debounce / long-press / repeat timings used by every key block.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_e;

    localparam logic KEY_PRESSED   = 1'b0;
    localparam int   SYNC_STAGES   = 2;

    // 20 ms, 1 s and 200 ms at a 50 MHz system clock
    localparam int DEF_DEB_CNT    = 1_000_000;
    localparam int DEF_LONG_CNT   = 50_000_000;
    localparam int DEF_REPEAT_CNT = 10_000_000;

endpackage

// File: rtl/key_sync.sv
// N-stage synchronizer for a slow asynchronous pin; resets to RESET_VAL so an
// active-low key reads as released while the chain fills.
module key_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[STAGES-2:0], din};
        end
    end

    assign dout = sync[STAGES-1];

endmodule

// File: rtl/key_event_filter.sv
// Debounces an active-low key and emits press / release / long-press pulses.
// Define KEY_REPEAT_EN to add auto-repeat press pulses after a long press.
module key_event_filter
    import key_pkg::*;
#(
    parameter int DEB_CNT    = DEF_DEB_CNT,
    parameter int LONG_CNT   = DEF_LONG_CNT,
    parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = $clog2(DEB_CNT);
    localparam int HOLD_W = $clog2(LONG_CNT + 1);

    if (DEB_CNT < 2 || LONG_CNT <= DEB_CNT || REPEAT_CNT < 2) begin : g_bad_params
        $error("key_event_filter: need DEB_CNT>=2, LONG_CNT>DEB_CNT, REPEAT_CNT>=2");
    end

    key_fsm_e          state, state_nxt;
    logic [DEB_W-1:0]  deb_cnt, deb_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              key_s;
    logic              held;
    logic              key_state_nxt, press_nxt, release_nxt, long_nxt;
    logic              rep_fire;

    key_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (key_in),
        .dout  (key_s)
    );

    assign held = (state == DOWN) || (state == REL_FILT);

    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        hold_nxt      = hold_cnt;
        key_state_nxt = key_state;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        long_nxt      = 1'b0;

        // Hold time keeps running through release filtering so a release that
        // is still being debounced cannot postpone the long-press event.
        if (held) begin
            if (hold_cnt != HOLD_W'(LONG_CNT)) begin
                hold_nxt = hold_cnt + 1'b1;
            end
            long_nxt = (hold_cnt == HOLD_W'(LONG_CNT - 2));
        end

        case (state)
            IDLE: begin
                if (key_s == KEY_PRESSED) begin
                    state_nxt = PRESS_FILT;
                    deb_nxt   = '0;
                end
            end
            PRESS_FILT: begin
                if (key_s != KEY_PRESSED) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
                    state_nxt     = DOWN;
                    press_nxt     = 1'b1;
                    key_state_nxt = 1'b1;
                    hold_nxt      = '0;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            DOWN: begin
                if (key_s != KEY_PRESSED) begin
                    state_nxt = REL_FILT;
                    deb_nxt   = '0;
                end
            end
            REL_FILT: begin
                if (key_s == KEY_PRESSED) begin
                    state_nxt = DOWN;
                end else if (deb_cnt == DEB_W'(DEB_CNT - 1)) begin
                    state_nxt     = IDLE;
                    release_nxt   = 1'b1;
                    key_state_nxt = 1'b0;
                    hold_nxt      = '0;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CNT);

    logic             rep_on, rep_on_nxt;
    logic [REP_W-1:0] rep_cnt, rep_nxt;

    // Repeat timer arms on the long-press event and only stops once the
    // release is accepted, so rejected release glitches leave it running.
    always_comb begin
        rep_on_nxt = rep_on;
        rep_nxt    = rep_cnt;
        rep_fire   = 1'b0;
        if (!held || state_nxt == IDLE) begin
            rep_on_nxt = 1'b0;
            rep_nxt    = '0;
        end else if (long_nxt) begin
            rep_on_nxt = 1'b1;
            rep_nxt    = '0;
        end else if (rep_on) begin
            if (rep_cnt == REP_W'(REPEAT_CNT - 1)) begin
                rep_nxt  = '0;
                rep_fire = 1'b1;
            end else begin
                rep_nxt = rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_on  <= 1'b0;
            rep_cnt <= '0;
        end else begin
            rep_on  <= rep_on_nxt;
            rep_cnt <= rep_nxt;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            key_state     <= key_state_nxt;
            press_pulse   <= press_nxt | rep_fire;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

endmodule

// File: tb/tb_key_event_filter.sv
// Randomised bench for key_event_filter: a run-length reference model feeds a
// scoreboard that an independent monitor drains as the DUT emits events.
module tb_key_event_filter;

    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic key_in = 1'b1;
    logic key_state, press_pulse, release_pulse, long_pulse;

    key_event_filter #(
        .DEB_CNT    (DEB),
        .LONG_CNT   (LONG),
        .REPEAT_CNT (REP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int cyc;
        bit press;
        bit rel;
        bit lng;
    } ev_t;

    ev_t expQ[$];
    bit  levelQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  model_presses = 0;
    int  seen_presses = 0;

    // Reference model: the key is a level seen two clocks late; an accepted
    // change needs DEB+1 consecutive samples differing from the stable level.
    bit  delay_line[$];
    bit  stable;
    int  run_len;
    bit  session;
    int  long_due;
    int  rep_due;
    bit  v;
    bit  rel_now;
    ev_t mev;

    always @(posedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            levelQ.delete();
            delay_line = {1'b1, 1'b1};
            stable   = 1'b1;
            run_len  = 0;
            session  = 1'b0;
            long_due = -1;
            rep_due  = -1;
            cyc      = 0;
        end else begin
            cyc = cyc + 1;
            delay_line.push_back(key_in);
            v = delay_line.pop_front();
            mev.cyc = cyc; mev.press = 1'b0; mev.rel = 1'b0; mev.lng = 1'b0;
            rel_now = 1'b0;
            if (v != stable) run_len++;
            else run_len = 0;
            if (run_len == DEB + 1) begin
                stable  = v;
                run_len = 0;
                if (v == 1'b0) begin
                    mev.press = 1'b1;
                    session   = 1'b1;
                    long_due  = cyc + LONG - 1;
                    rep_due   = -1;
                end else begin
                    mev.rel = 1'b1;
                    rel_now = 1'b1;
                end
            end
            if (session && cyc == long_due) begin
                mev.lng = 1'b1;
                rep_due = cyc + REP;
            end
`ifdef KEY_REPEAT_EN
            if (session && !rel_now && cyc == rep_due) begin
                mev.press = 1'b1;
                rep_due   = rep_due + REP;
            end
`endif
            if (rel_now) session = 1'b0;
            if (mev.press) model_presses++;
            levelQ.push_back(!stable);
            if (mev.press || mev.rel || mev.lng) expQ.push_back(mev);
        end
    end

    ev_t got;

    always @(negedge clk) begin
        if (rst_n) begin
            if (levelQ.size() > 0) begin
                checks++;
                if (key_state !== levelQ[0]) begin
                    errors++;
                    $display("[TB] FAIL key_state cyc=%0d actual=%b expected=%b", cyc, key_state, levelQ[0]);
                end
                void'(levelQ.pop_front());
            end
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_event cyc=%0d expected p/r/l=%b%b%b at cyc %0d",
                         cyc, expQ[0].press, expQ[0].rel, expQ[0].lng, expQ[0].cyc);
                void'(expQ.pop_front());
            end
            if (press_pulse || release_pulse || long_pulse ||
                (expQ.size() > 0 && expQ[0].cyc == cyc)) begin
                checks++;
                if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                    got = expQ.pop_front();
                    if ({press_pulse, release_pulse, long_pulse} !== {got.press, got.rel, got.lng}) begin
                        errors++;
                        $display("[TB] FAIL pulses cyc=%0d actual p/r/l=%b%b%b expected=%b%b%b", cyc,
                                 press_pulse, release_pulse, long_pulse, got.press, got.rel, got.lng);
                    end
                end else begin
                    errors++;
                    $display("[TB] FAIL unexpected_pulse cyc=%0d actual p/r/l=%b%b%b expected=000",
                             cyc, press_pulse, release_pulse, long_pulse);
                end
            end
            if (press_pulse === 1'b1) seen_presses++;
        end
    end

    task automatic drive_key(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_key_state"}, key_state, 1'b0);
        check_output({tag, "_press"}, press_pulse, 1'b0);
        check_output({tag, "_release"}, release_pulse, 1'b0);
        check_output({tag, "_long"}, long_pulse, 1'b0);
    endtask

    task automatic apply_stimulus();
        // clean long press, then bounce train, release glitch, short press
        drive_key(1'b0, 30);
        drive_key(1'b1, 20);
        for (int i = 0; i < 6; i++) begin
            drive_key(1'b0, 1 + int'($urandom_range(0, 2)));
            drive_key(1'b1, 1 + int'($urandom_range(0, 2)));
        end
        drive_key(1'b1, 10);
        drive_key(1'b0, 12);
        drive_key(1'b1, 2);
        drive_key(1'b0, 25);
        drive_key(1'b1, 15);
        drive_key(1'b0, 10);
        drive_key(1'b1, 15);

        // reset while the key is held; it must re-qualify afterwards
        drive_key(1'b0, 15);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_key(1'b0, 15);
        drive_key(1'b1, 15);

        // long hold exercises the repeat path when enabled
        drive_key(1'b0, 60);
        drive_key(1'b1, 20);

        for (int i = 0; i < 40; i++) begin
            drive_key(1'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 29)));
        end
        drive_key(1'b1, 40);
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus();
        @(negedge clk);
        check_output("scoreboard_empty", expQ.size() == 0, 1'b1);
        checks++;
        if (seen_presses != model_presses) begin
            errors++;
            $display("[TB] FAIL press_count actual=%0d expected=%0d", seen_presses, model_presses);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
